// File: rtl/sine_phase_sequencer_pkg.sv
// Shared types and helpers for the 3-phase sine sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sine_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        RD_C = 3'd3,
        LAST = 3'd4
    } state_t;

    // 120 degree offset expressed in ROM address steps
    function automatic int unsigned ofs1_f(input int unsigned depth);
        return (32'd1 << depth) / 32'd3;
    endfunction

    // 240 degree offset expressed in ROM address steps
    function automatic int unsigned ofs2_f(input int unsigned depth);
        return (32'd2 << depth) / 32'd3;
    endfunction

endpackage

// File: rtl/sine_phase_acc.sv
// Phase accumulator with frequency shadow register and carry-out detect.
// Latency: acc/wrap update one edge after update_in; base_out is the registered acc MSBs.
// Backpressure: none; update_in is a single-cycle strobe from the sequencer FSM.
module sine_phase_acc #(
    parameter int DEPTH_P = 8,
    parameter int ACC_W_P = 24
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               update_in,
    input  logic [ACC_W_P-1:0] freq_word_in,
    output logic [DEPTH_P-1:0] base_out,
    output logic               wrap_out
);

    logic [ACC_W_P-1:0] acc_q;
    logic [ACC_W_P-1:0] shadow_q;
    logic [ACC_W_P:0]   sum;

    assign sum      = {1'b0, acc_q} + {1'b0, shadow_q};
    assign base_out = acc_q[ACC_W_P-1 -: DEPTH_P];

    // Disabled: clear phase and follow the frequency word. Enabled: advance
    // once per sample, and only pick up a new frequency at the period wrap so
    // the phase never jumps mid-cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q    <= '0;
            shadow_q <= '0;
            wrap_out <= 1'b0;
        end else if (!enable_in) begin
            acc_q    <= '0;
            shadow_q <= freq_word_in;
            wrap_out <= 1'b0;
        end else begin
            wrap_out <= 1'b0;
            if (update_in) begin
                acc_q    <= sum[ACC_W_P-1:0];
                wrap_out <= sum[ACC_W_P];
                if (sum[ACC_W_P]) begin
                    shadow_q <= freq_word_in;
                end
            end
        end
    end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Reads three phase-shifted samples from a shared registered sine ROM per tick.
// Latency: 5 cycles from accepted tick to sample_valid_out; ticks < 5 cycles apart are dropped.
// Backpressure: none; ticks arriving while busy are ignored and flagged in overrun_out.
// Optional: define SINE_SEQ_REVERSE_EN to add dir_in (swaps the B/C phase offsets).
module sine_phase_sequencer
    import sine_pkg::*;
#(
    parameter int DEPTH_P = 8,
    parameter int WIDTH_P = 12,
    parameter int ACC_W_P = 24
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               sample_tick_in,
    input  logic [ACC_W_P-1:0] freq_word_in,
`ifdef SINE_SEQ_REVERSE_EN
    input  logic               dir_in,
`endif
    output logic [DEPTH_P-1:0] rom_addr_out,
    input  logic [WIDTH_P-1:0] rom_data_in,
    output logic [WIDTH_P-1:0] sine_a_out,
    output logic [WIDTH_P-1:0] sine_b_out,
    output logic [WIDTH_P-1:0] sine_c_out,
    output logic               sample_valid_out,
    output logic               busy_out,
    output logic               wrap_out,
    output logic               overrun_out
);

    localparam logic [DEPTH_P-1:0] OFS1 = DEPTH_P'(ofs1_f(DEPTH_P));
    localparam logic [DEPTH_P-1:0] OFS2 = DEPTH_P'(ofs2_f(DEPTH_P));

    state_t             state_q, state_d;
    logic [DEPTH_P-1:0] addr_d;
    logic [DEPTH_P-1:0] base;
    logic [DEPTH_P-1:0] ofs_b, ofs_c;
    logic               en_q;
    logic               tick_accept;
    logic               acc_update;

    // en_q blocks a tick that lands in the same cycle enable rises
    assign tick_accept = sample_tick_in && enable_in && en_q && (state_q == IDLE);
    assign acc_update  = enable_in && (state_q == LAST);
    assign busy_out    = (state_q != IDLE);

`ifdef SINE_SEQ_REVERSE_EN
    logic dir_q;

    // Direction is latched with the tick so one sample uses a single order
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dir_q <= 1'b0;
        end else if (tick_accept) begin
            dir_q <= dir_in;
        end
    end

    assign ofs_b = dir_q ? OFS2 : OFS1;
    assign ofs_c = dir_q ? OFS1 : OFS2;
`else
    assign ofs_b = OFS1;
    assign ofs_c = OFS2;
`endif

    sine_phase_acc #(
        .DEPTH_P (DEPTH_P),
        .ACC_W_P (ACC_W_P)
    ) u_acc (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .enable_in    (enable_in),
        .update_in    (acc_update),
        .freq_word_in (freq_word_in),
        .base_out     (base),
        .wrap_out     (wrap_out)
    );

    // State and ROM address registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            rom_addr_out <= '0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_out <= addr_d;
            en_q         <= enable_in;
        end
    end

    // Next state; the address for each read state is loaded on entry so the
    // ROM sees it for the whole state
    always_comb begin
        state_d = state_q;
        addr_d  = rom_addr_out;
        case (state_q)
            IDLE: begin
                if (tick_accept) begin
                    state_d = RD_A;
                    addr_d  = base;
                end
            end
            RD_A: begin
                state_d = RD_B;
                addr_d  = base + ofs_b;
            end
            RD_B: begin
                state_d = RD_C;
                addr_d  = base + ofs_c;
            end
            RD_C:    state_d = LAST;
            LAST:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable_in) begin
            state_d = IDLE;
            addr_d  = rom_addr_out;
        end
    end

    // Capture ROM data one state after each address; nothing lands when disabled
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sine_a_out       <= '0;
            sine_b_out       <= '0;
            sine_c_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= acc_update;
            if (enable_in) begin
                case (state_q)
                    RD_B:    sine_a_out <= rom_data_in;
                    RD_C:    sine_b_out <= rom_data_in;
                    LAST:    sine_c_out <= rom_data_in;
                    default: ;
                endcase
            end
        end
    end

    // Sticky overrun flag, cleared only by disabling
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overrun_out <= 1'b0;
        end else if (!enable_in) begin
            overrun_out <= 1'b0;
        end else if (sample_tick_in && (state_q != IDLE)) begin
            overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed bench for sine_phase_sequencer with a data=address registered ROM.
// Latency: checks valid 5 cycles after the tick cycle.
// Backpressure: exercises tick overrun and mid-sequence abort.
module tb_sine_phase_sequencer;

    localparam int DEPTH_P = 8;
    localparam int WIDTH_P = 12;
    localparam int ACC_W_P = 24;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               enable_in;
    logic               sample_tick_in;
    logic [ACC_W_P-1:0] freq_word_in;
`ifdef SINE_SEQ_REVERSE_EN
    logic               dir_in;
`endif
    logic [DEPTH_P-1:0] rom_addr_out;
    logic [WIDTH_P-1:0] rom_data_in;
    logic [WIDTH_P-1:0] sine_a_out, sine_b_out, sine_c_out;
    logic               sample_valid_out, busy_out, wrap_out, overrun_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    // Registered ROM whose contents equal the address
    always @(posedge clk_in) rom_data_in <= WIDTH_P'(rom_addr_out);

    sine_phase_sequencer #(
        .DEPTH_P (DEPTH_P),
        .WIDTH_P (WIDTH_P),
        .ACC_W_P (ACC_W_P)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .sample_tick_in   (sample_tick_in),
        .freq_word_in     (freq_word_in),
`ifdef SINE_SEQ_REVERSE_EN
        .dir_in           (dir_in),
`endif
        .rom_addr_out     (rom_addr_out),
        .rom_data_in      (rom_data_in),
        .sine_a_out       (sine_a_out),
        .sine_b_out       (sine_b_out),
        .sine_c_out       (sine_c_out),
        .sample_valid_out (sample_valid_out),
        .busy_out         (busy_out),
        .wrap_out         (wrap_out),
        .overrun_out      (overrun_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Disable for one cycle (clears acc, loads freq), then enable for one
    // cycle so the next tick is accepted
    task automatic restart(input logic [ACC_W_P-1:0] f);
        enable_in    = 1'b0;
        freq_word_in = f;
        step();
        enable_in = 1'b1;
        step();
    endtask

    // Tick in the current cycle T; valid expected in T+5; returns at T+8
    task automatic run_sample(input string tag, input int ea, input int eb, input int ec, input int ew);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        chk({tag, "_busy"}, busy_out, 1);
        chk({tag, "_addr_a"}, rom_addr_out, ea);
        step();
        step();
        step();
        chk({tag, "_early_vld"}, sample_valid_out, 0);
        step();
        chk({tag, "_vld"}, sample_valid_out, 1);
        chk({tag, "_a"}, sine_a_out, ea);
        chk({tag, "_b"}, sine_b_out, eb);
        chk({tag, "_c"}, sine_c_out, ec);
        chk({tag, "_wrap"}, wrap_out, ew);
        chk({tag, "_idle"}, busy_out, 0);
        step();
        chk({tag, "_vld_pulse"}, sample_valid_out, 0);
        chk({tag, "_wrap_pulse"}, wrap_out, 0);
        step();
        step();
    endtask

    initial begin
        rst_in         = 1'b1;
        enable_in      = 1'b0;
        sample_tick_in = 1'b0;
        freq_word_in   = 24'h010000;
`ifdef SINE_SEQ_REVERSE_EN
        dir_in         = 1'b0;
`endif
        step();
        step();
        chk("rst_addr", rom_addr_out, 0);
        chk("rst_a", sine_a_out, 0);
        chk("rst_b", sine_b_out, 0);
        chk("rst_c", sine_c_out, 0);
        chk("rst_vld", sample_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_wrap", wrap_out, 0);
        chk("rst_ovr", overrun_out, 0);
        rst_in = 1'b0;
        step();

        // Basic stepping by one ROM address per sample
        restart(24'h010000);
        run_sample("s1_0", 0, 85, 170, 0);
        run_sample("s1_1", 1, 86, 171, 0);
        chk("addr_hold", rom_addr_out, 171);

        // Half-period steps, wrap on the second update
        restart(24'h800000);
        run_sample("s2_0", 0, 85, 170, 0);
        run_sample("s2_1", 128, 213, 42, 1);
        run_sample("s2_2", 0, 85, 170, 0);

        // Frequency change only takes effect after the wrap
        restart(24'h400000);
        run_sample("s3_0", 0, 85, 170, 0);
        freq_word_in = 24'h010000;
        run_sample("s3_1", 64, 149, 234, 0);
        run_sample("s3_2", 128, 213, 42, 0);
        run_sample("s3_3", 192, 21, 106, 1);
        run_sample("s3_4", 0, 85, 170, 0);
        run_sample("s3_5", 1, 86, 171, 0);

        // Second tick two cycles after the first: dropped, overrun set
        restart(24'h010000);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        step();
        chk("ovr_pre", overrun_out, 0);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        chk("ovr_set", overrun_out, 1);
        step();
        chk("ovr_no_early_vld", sample_valid_out, 0);
        step();
        chk("ovr_vld", sample_valid_out, 1);
        chk("ovr_a", sine_a_out, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("ovr_single_vld", sample_valid_out, 0);
        end
        chk("ovr_sticky", overrun_out, 1);
        enable_in = 1'b0;
        step();
        chk("ovr_clear", overrun_out, 0);

        // Tick in the same cycle enable rises is ignored
        enable_in      = 1'b1;
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        chk("rise_tick_ignored", busy_out, 0);
        step();

        // Abort during RD_B after one good sample (acc now nonzero)
        run_sample("s5_0", 0, 85, 170, 0);
        sample_tick_in = 1'b1;
        step();
        sample_tick_in = 1'b0;
        step();
        enable_in = 1'b0;
        step();
        chk("abort_busy", busy_out, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_vld", sample_valid_out, 0);
        end
        chk("abort_a", sine_a_out, 0);
        chk("abort_b", sine_b_out, 85);
        chk("abort_c", sine_c_out, 170);
        enable_in = 1'b1;
        step();
        run_sample("s5_acc0", 0, 85, 170, 0);

`ifdef SINE_SEQ_REVERSE_EN
        // Reversed phase order from acc 0
        restart(24'h010000);
        dir_in = 1'b1;
        run_sample("rev", 0, 170, 85, 0);
        dir_in = 1'b0;
        run_sample("fwd", 1, 86, 171, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sine_phase_sequencer.md
SINE_PHASE_SEQUENCER -- requirements
Module: sine_phase_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_P, default 8: sine ROM address width, giving 2**DEPTH_P samples per period.
REQ-002 SHALL have parameter WIDTH_P, default 12: amplitude width in bits.
REQ-003 SHALL have parameter ACC_W_P, default 24: phase accumulator width; ACC_W_P > DEPTH_P.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk_in, in, 1: single clock.
- rst_in, in, 1: synchronous, active-high reset.
- enable_in, in, 1: run when high, abort/clear when low.
- sample_tick_in, in, 1: one-cycle request for a new 3-phase sample.
- freq_word_in, in, ACC_W_P: phase increment per sample.
- rom_addr_out, out, DEPTH_P: address to the shared registered sine ROM.
- rom_data_in, in, WIDTH_P: ROM data, valid 1 cycle after its address.
- sine_a_out / sine_b_out / sine_c_out, out, WIDTH_P each: phase A/B/C amplitudes.
- sample_valid_out, out, 1: one-cycle pulse when sine_a/b/c are updated.
- busy_out, out, 1: read sequence in progress.
- wrap_out, out, 1: one-cycle pulse on accumulator carry-out.
- overrun_out, out, 1: sticky; tick arrived while busy.

Function
REQ-005 SHALL use FSM states IDLE, RD_A, RD_B, RD_C, LAST: IDLE->RD_A on tick with enable high; then RD_A->RD_B->RD_C->LAST->IDLE unconditionally.
REQ-006 SHALL drive rom_addr_out = addr_A in RD_A, addr_B in RD_B, addr_C in RD_C, and hold the last address otherwise.
REQ-007 SHALL capture rom_data_in into sine_a_out at the end of RD_B, sine_b_out at the end of RD_C, and sine_c_out at the end of LAST.
REQ-008 SHALL pulse sample_valid_out in the cycle after LAST, giving 5 cycles from tick sample edge to valid; minimum accepted tick spacing is 5 cycles.
REQ-009 SHALL compute base = acc[ACC_W_P-1 -: DEPTH_P]; addr_A = base; addr_B = base + OFS1; addr_C = base + OFS2, all mod 2**DEPTH_P; OFS1 = floor(2**DEPTH_P/3), OFS2 = floor(2*2**DEPTH_P/3).
REQ-010 SHALL hold the accumulator constant from RD_A through LAST, then update acc <= acc + freq_shadow mod 2**ACC_W_P at the end of LAST.
REQ-011 SHALL pulse wrap_out for one cycle on an update with carry-out, coincident with sample_valid_out.
REQ-012 SHALL track freq_word_in continuously in freq_shadow while enable_in is low, and reload it only on a wrap update while enabled.
REQ-013 SHALL keep busy_out high in RD_A..LAST only.
REQ-014 SHALL ignore sample_tick_in while not IDLE, and set overrun_out in the next cycle.
REQ-015 SHALL, on enable_in low, go to IDLE at the next edge (aborting any sequence), clear acc to 0, clear overrun_out, and suppress sample_valid_out and wrap_out; sine outputs hold.
REQ-016 SHALL ignore ticks while enable_in is low, including a tick in the same cycle enable rises.

Reset
REQ-017 SHALL, on rst_in high, set state IDLE, acc 0, freq_shadow 0, rom_addr_out 0, and sine_a/b/c_out, sample_valid_out, busy_out, wrap_out and overrun_out to 0.
REQ-018 SHALL give rst_in priority over every other input.

Configuration
REQ-019 SHALL, when SINE_SEQ_REVERSE_EN is defined, add input dir_in (1 bit), sampled in IDLE on tick acceptance; dir_in=1 swaps the offsets (addr_B uses OFS2, addr_C uses OFS1).
REQ-020 SHALL, when SINE_SEQ_REVERSE_EN is undefined, omit the dir_in port and use the fixed forward order.

Structure
REQ-021 SHALL define the FSM state enum and the OFS1/OFS2 computation functions in shared package sine_pkg.
REQ-022 SHALL put the accumulator, shadow register and wrap detect in sub-module sine_phase_acc; the FSM and capture logic stay at the top.

Verification (DEPTH_P=8, ACC_W_P=24, ROM model data=address, 1-cycle latency)
REQ-023 SHALL check: freq 0x010000, enable, ticks every 8 cycles -> valid 5 cycles after each tick with (A,B,C) = (0,85,170), then (1,86,171).
REQ-024 SHALL check: freq 0x800000 -> samples (0,85,170), (128,213,42), (0,85,170); wrap_out pulses with the 2nd-update valid.
REQ-025 SHALL check: freq 0x400000, change freq_word_in to 0x010000 after the 1st sample -> steps of 64 until the wrap, then steps of 1.
REQ-026 SHALL check: tick at T and T+2 -> one valid at T+5, overrun_out high from T+3 until enable drops.
REQ-027 SHALL check: enable low during RD_B -> no valid, busy_out 0 next cycle, acc 0, sine outputs unchanged.
REQ-028 SHALL check, with SINE_SEQ_REVERSE_EN and dir_in=1 at acc 0 -> (0,170,85).
